// File: rtl/voxel_pixel_burst_writer.sv
// voxel_pixel_burst_writer: coalesces contiguous pixels into write bursts toward host framebuffer memory
module voxel_pixel_burst_writer #(
  parameter int FIFO_DEPTH    = 64,
  parameter int MAX_BURST_PIX = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pixel_write_en,
  input  logic [31:0]                   pixel_addr,
  input  logic [31:0]                   pixel_word0,
  input  logic [31:0]                   pixel_word1,
  input  logic [31:0]                   pixel_word2,
  input  logic                          frame_done,
  input  logic [31:0]                   fb_base,
  input  logic                          clear_stats,
  output logic                          m_aw_valid,
  input  logic                          m_aw_ready,
  output logic [31:0]                   m_aw_addr,
  output logic [7:0]                    m_aw_len,
  output logic                          m_w_valid,
  input  logic                          m_w_ready,
  output logic [31:0]                   m_w_data,
  output logic                          m_w_last,
  output logic                          frame_flushed,
  output logic                          overflow_sticky,
  output logic [31:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(MAX_BURST_PIX + 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_n;
  logic [95:0]      dmem [FIFO_DEPTH];
  logic [32+LW-1:0] qmem [FIFO_DEPTH];
  logic [AW-1:0]    dwp, drp, qwp, qrp;
  logic [AW:0]      dcnt, qcnt;
  logic             run_open, close_req, broken, flush_pending;
  logic [31:0]      run_start;
  logic [LW-1:0]    run_len;
  logic [7:0]       beat;
  logic [1:0]       sel;
  logic [95:0]      head;
  logic [32+LW-1:0] qh;
  logic             wbeat, d_pop, accept, drop, ext, q_push, q_pop;
  always_comb begin
    head          = dmem[drp];
    qh            = qmem[qrp];
    m_aw_valid    = state == ADDR;
    m_w_valid     = state == DATA;
    wbeat         = m_w_valid && m_w_ready;
    d_pop         = wbeat && sel == 2'd2;
    accept        = pixel_write_en && (dcnt != (AW+1)'(FIFO_DEPTH) || d_pop);
    drop          = pixel_write_en && !accept;
    ext           = accept && run_open && !close_req && !broken &&
                    ({1'b0, run_start} + 33'(run_len)) == {1'b0, pixel_addr} &&
                    run_len < LW'(MAX_BURST_PIX);
    q_push        = run_open && (close_req || (accept && !ext));
    q_pop         = state == IDLE && qcnt != '0;
    m_w_data      = !m_w_valid ? 32'd0 : sel == 2'd0 ? head[31:0] : sel == 2'd1 ? head[63:32] : head[95:64];
    m_w_last      = m_w_valid && beat == m_aw_len;
    frame_flushed = flush_pending && !close_req && !run_open && dcnt == '0 && qcnt == '0 && state == IDLE;
    fifo_level    = dcnt;
    state_n       = state;
    state_n       = q_pop ? ADDR :
                    (state == ADDR && m_aw_ready) ? DATA :
                    (wbeat && m_w_last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (accept) dmem[dwp] <= {pixel_word2, pixel_word1, pixel_word0};
    if (q_push) qmem[qwp] <= {run_start, run_len};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      dwp             <= '0;
      drp             <= '0;
      qwp             <= '0;
      qrp             <= '0;
      dcnt            <= '0;
      qcnt            <= '0;
      run_open        <= 1'b0;
      run_start       <= '0;
      run_len         <= '0;
      close_req       <= 1'b0;
      broken          <= 1'b0;
      flush_pending   <= 1'b0;
      beat            <= '0;
      sel             <= '0;
      m_aw_addr       <= '0;
      m_aw_len        <= '0;
      drop_count      <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      state         <= state_n;
      dwp           <= dwp + AW'(accept);
      drp           <= drp + AW'(d_pop);
      qwp           <= qwp + AW'(q_push);
      qrp           <= qrp + AW'(q_pop);
      dcnt          <= dcnt + (AW+1)'(accept) - (AW+1)'(d_pop);
      qcnt          <= qcnt + (AW+1)'(q_push) - (AW+1)'(q_pop);
      close_req     <= frame_done;
      broken        <= drop ? 1'b1 : accept ? 1'b0 : broken;
      flush_pending <= frame_done || (flush_pending && !frame_flushed);
      if (accept) begin
        run_open  <= 1'b1;
        run_start <= ext ? run_start : pixel_addr;
        run_len   <= ext ? run_len + 1'b1 : LW'(1);
      end else if (close_req) begin
        run_open <= 1'b0;
      end
      if (q_pop) begin
        m_aw_addr <= fb_base + qh[32+LW-1:LW] * 32'd12;
        m_aw_len  <= 8'(3 * int'(qh[LW-1:0]) - 1);
        beat      <= '0;
        sel       <= '0;
      end else if (wbeat) begin
        beat <= beat + 8'd1;
        sel  <= sel == 2'd2 ? 2'd0 : sel + 2'd1;
      end
      drop_count      <= clear_stats ? 32'd0 : (drop && drop_count != 32'hFFFF_FFFF) ? drop_count + 32'd1 : drop_count;
      overflow_sticky <= clear_stats ? 1'b0 : overflow_sticky || drop;
    end
  end
endmodule

// File: tb/tb_voxel_pixel_burst_writer.sv
// tb_voxel_pixel_burst_writer: scoreboard bench, directed pixel streams against queued expected bursts
module tb_voxel_pixel_burst_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_write_en = 1'b0;
  logic [31:0] pixel_addr = '0, pixel_word0 = '0, pixel_word1 = '0, pixel_word2 = '0;
  logic        frame_done = 1'b0;
  logic [31:0] fb_base = 32'h1000_0000;
  logic        clear_stats = 1'b0;
  logic        m_aw_valid, m_aw_ready = 1'b1;
  logic [31:0] m_aw_addr;
  logic [7:0]  m_aw_len;
  logic        m_w_valid, m_w_ready = 1'b1;
  logic [31:0] m_w_data;
  logic        m_w_last, frame_flushed, overflow_sticky;
  logic [31:0] drop_count;
  logic [6:0]  fifo_level;
  voxel_pixel_burst_writer dut (
    .clk(clk), .rst(rst), .pixel_write_en(pixel_write_en), .pixel_addr(pixel_addr),
    .pixel_word0(pixel_word0), .pixel_word1(pixel_word1), .pixel_word2(pixel_word2),
    .frame_done(frame_done), .fb_base(fb_base), .clear_stats(clear_stats),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_last(m_w_last),
    .frame_flushed(frame_flushed), .overflow_sticky(overflow_sticky), .drop_count(drop_count),
    .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  int nchk = 0, nfail = 0, aw_hs = 0, w_hs = 0, fl_cnt = 0;
  bit rnd = 0;
  logic [39:0] exp_aw [$];
  logic [32:0] exp_w [$];
  logic [39:0] ea;
  logic [32:0] ew;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_last = 0;
  logic [31:0] p_addr = '0, p_data = '0;
  logic [7:0]  p_len = '0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] wd(logic [31:0] a, int k);
    logic [31:0] kk = k;
    return {kk[1:0], 2'b01, a[27:0]};
  endfunction
  task automatic exp_burst(logic [31:0] base, logic [31:0] start, int n);
    exp_aw.push_back({base + start * 32'd12, 8'(3 * n - 1)});
    for (int p = 0; p < n; p++)
      for (int k = 0; k < 3; k++)
        exp_w.push_back({p == n - 1 && k == 2, wd(start + p, k)});
  endtask
  always @(negedge clk) begin
    if (rst) begin
      p_awv = 0;
      p_wv  = 0;
    end else begin
      if (p_awv && !p_awr) check("aw_stable", {m_aw_valid, m_aw_addr, m_aw_len}, {1'b1, p_addr, p_len});
      if (p_wv && !p_wr) check("w_stable", {m_w_valid, m_w_last, m_w_data}, {1'b1, p_last, p_data});
      if (m_aw_valid && m_aw_ready) begin
        aw_hs++;
        if (exp_aw.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL aw_unexpected: got addr %0h len %0d, none expected", m_aw_addr, m_aw_len);
        end else begin
          ea = exp_aw.pop_front();
          check("aw", {m_aw_addr, m_aw_len}, ea);
        end
      end
      if (m_w_valid && m_w_ready) begin
        w_hs++;
        if (exp_w.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL w_unexpected: got data %0h, none expected", m_w_data);
        end else begin
          ew = exp_w.pop_front();
          check("w", {m_w_last, m_w_data}, ew);
        end
      end
      if (frame_flushed) begin
        fl_cnt++;
        check("flush_after_last", exp_w.size(), 0);
      end
      p_awv = m_aw_valid; p_awr = m_aw_ready; p_addr = m_aw_addr; p_len = m_aw_len;
      p_wv = m_w_valid; p_wr = m_w_ready; p_data = m_w_data; p_last = m_w_last;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
    if (rnd) begin
      m_aw_ready = 1'($urandom % 2);
      m_w_ready  = 1'($urandom % 2);
    end
  endtask
  task automatic px(logic [31:0] a, logic fd);
    pixel_write_en = 1'b1;
    pixel_addr  = a;
    pixel_word0 = wd(a, 0);
    pixel_word1 = wd(a, 1);
    pixel_word2 = wd(a, 2);
    frame_done  = fd;
    tick;
    pixel_write_en = 1'b0;
    frame_done = 1'b0;
  endtask
  task automatic fdone;
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
  endtask
  task automatic drain(int fl_exp);
    int n = 0;
    while ((exp_aw.size() != 0 || exp_w.size() != 0) && n < 3000) begin
      tick;
      n++;
    end
    check("drain_in_time", n < 3000, 1);
    rnd = 0;
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    repeat (6) tick;
    check("flush_count", fl_cnt, fl_exp);
  endtask
  task automatic chk_zero(string tag);
    check({tag, "_awv"}, m_aw_valid, 0);
    check({tag, "_awaddr"}, m_aw_addr, 0);
    check({tag, "_awlen"}, m_aw_len, 0);
    check({tag, "_wv"}, m_w_valid, 0);
    check({tag, "_wdata"}, m_w_data, 0);
    check({tag, "_wlast"}, m_w_last, 0);
    check({tag, "_flushed"}, frame_flushed, 0);
    check({tag, "_sticky"}, overflow_sticky, 0);
    check({tag, "_drops"}, drop_count, 0);
    check({tag, "_level"}, fifo_level, 0);
  endtask
  initial begin
    int a0, w0, n;
    repeat (3) tick;
    chk_zero("reset");
    rst = 1'b0;
    tick;
    a0 = aw_hs;
    exp_burst(32'h1000_0000, 0, 16);
    exp_burst(32'h1000_0000, 16, 16);
    exp_burst(32'h1000_0000, 32, 8);
    for (int i = 0; i < 40; i++) px(i, 0);
    repeat (120) tick;
    check("seq_held_bursts", aw_hs - a0, 2);
    check("seq_held_beats", exp_w.size(), 24);
    check("seq_no_early_flush", fl_cnt, 0);
    fdone;
    drain(1);
    fb_base = 32'hFFFF_FFF0;
    exp_burst(fb_base, 5, 2);
    exp_burst(fb_base, 9, 3);
    px(5, 0); px(6, 0); px(9, 0); px(10, 0); px(11, 0);
    fdone;
    drain(2);
    fb_base = 32'h1000_0000;
    exp_burst(fb_base, 4, 4);
    px(4, 0); px(5, 0); px(6, 0); px(7, 1);
    drain(3);
    m_w_ready = 1'b0;
    for (int b = 0; b < 4; b++) exp_burst(fb_base, b * 16, 16);
    for (int i = 0; i < 70; i++) px(i, 0);
    check("ovf_drops", drop_count, 6);
    check("ovf_sticky", overflow_sticky, 1);
    check("ovf_level", fifo_level, 64);
    fdone;
    m_w_ready = 1'b1;
    drain(4);
    check("ovf_level_drained", fifo_level, 0);
    check("ovf_drops_kept", drop_count, 6);
    clear_stats = 1'b1;
    tick;
    clear_stats = 1'b0;
    check("clear_drops", drop_count, 0);
    check("clear_sticky", overflow_sticky, 0);
    fb_base = 32'h0004_0000;
    rnd = 1;
    exp_burst(fb_base, 200, 16);
    exp_burst(fb_base, 216, 4);
    for (int i = 200; i < 220; i++) px(i, 0);
    fdone;
    drain(5);
    exp_burst(fb_base, 32'hFFFF_FFFF, 1);
    exp_burst(fb_base, 0, 1);
    px(32'hFFFF_FFFF, 0); px(0, 0);
    fdone;
    drain(6);
    exp_burst(fb_base, 100, 16);
    w0 = w_hs;
    for (int i = 100; i < 116; i++) px(i, 0);
    fdone;
    n = 0;
    while (w_hs < w0 + 5 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_wait_in_time", n < 500, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_w_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    check("midrst_beats", w_hs - w0, 5);
    exp_aw.delete();
    exp_w.delete();
    rst = 1'b0;
    m_w_ready = 1'b1;
    tick;
    exp_burst(fb_base, 0, 1);
    px(0, 1);
    drain(7);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/voxel_pixel_burst_writer.md
Name: voxel_pixel_burst_writer

Overview:
- Sits directly downstream of the voxel framebuffer top.
- Accepts its raw pixel stream: write enable, pixel index and three 32-bit words per pixel, plus the frame-done pulse.
- Buffers the stream and coalesces address-contiguous pixels into burst descriptors.
- Drives a valid/ready address+data write master toward host framebuffer memory, and reports when a finished frame has fully drained.

Parameters:
- FIFO_DEPTH, 64, pixel data FIFO entries (power of 2, >=4); descriptor FIFO has the same depth.
- MAX_BURST_PIX, 16, maximum pixels per burst (1..85, so that 3*MAX_BURST_PIX-1 fits in 8 bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- pixel_write_en  in  1  pixel valid. No backpressure is available upstream.
- pixel_addr  in  32  pixel index.
- pixel_word0 / pixel_word1 / pixel_word2  in  32 each  pixel payload.
- frame_done  in  1  end-of-frame pulse from the core.
- fb_base  in  32  framebuffer byte base address, sampled when each burst header is issued.
- clear_stats  in  1  clears drop_count and overflow_sticky.
- m_aw_valid  out  1  burst address valid.
- m_aw_ready  in  1  burst address ready.
- m_aw_addr  out  32  burst byte address.
- m_aw_len  out  8  number of beats minus 1.
- m_w_valid  out  1  data beat valid.
- m_w_ready  in  1  data beat ready.
- m_w_data  out  32  data beat.
- m_w_last  out  1  last beat of the burst.
- frame_flushed  out  1  one-cycle pulse: the frame has fully drained.
- overflow_sticky  out  1  set when any pixel has been dropped.
- drop_count  out  32  count of dropped pixels, saturating.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  pixel data FIFO occupancy.

Behaviour:
- Reset (rst=1 at clk edge):
  - Both FIFOs are emptied, the open run is cleared and flush_pending is cleared.
  - The output FSM goes to IDLE.
  - All outputs go to 0.
  - A burst in flight is abandoned mid-burst; no further beats are issued.
- Input acceptance:
  - A pixel is accepted when pixel_write_en=1 and the data FIFO is not full. Its word0..2 are pushed as one entry in the same cycle.
  - When the data FIFO is full, the pixel is dropped: drop_count increments (saturating at 0xFFFFFFFF) and overflow_sticky sets.
  - A dropped pixel breaks the run: the next accepted pixel always starts a new run.
  - clear_stats has priority over an increment in the same cycle.
- Run builder (registers run_open, run_start[31:0], run_len):
  - An accepted pixel extends the open run only if all of the following hold: run_open=1, flush_pending_close=0, the 33-bit sum run_start+run_len equals the pixel address, and run_len<MAX_BURST_PIX. Because the sum is 33 bits, wrap from 0xFFFFFFFF to 0 is a break.
  - Otherwise the open run (if any) is pushed to the descriptor FIFO as {run_start, run_len}, and a new run starts with run_start=addr, run_len=1.
  - At most one descriptor push occurs per cycle.
- Frame end:
  - frame_done=1 sets a close request, registered for the next cycle.
  - In the cycle the close request is set, the open run is pushed. A pixel accepted in that same cycle starts a fresh run, which stays open.
  - frame_done also sets flush_pending.
  - A pixel arriving in the same cycle as frame_done belongs to the run being closed.
- Output FSM:
  - IDLE: when the descriptor FIFO is non-empty, pop one descriptor and go to ADDR.
  - ADDR: m_aw_valid=1, m_aw_addr = fb_base + run_start*12 (mod 2^32), m_aw_len = 3*len-1. Outputs are held stable until m_aw_ready; then go to DATA.
  - DATA:
    - Beats are emitted in order word0, word1, word2 from the data FIFO head. The entry is popped on the handshake of word2.
    - m_w_valid stays high and the data stays stable until m_w_ready.
    - m_w_last=1 on the final beat. After its handshake, return to IDLE.
    - The descriptor guarantees that the data is present, so there are no bubbles from the FIFO side.
- Flush completion:
  - frame_flushed pulses for one cycle when all of the following hold: flush_pending=1, no close request is outstanding, run_open=0, both FIFOs are empty, and the FSM is IDLE.
  - flush_pending clears on that pulse.
  - A repeated frame_done before the drain completes is merged: only one pulse is produced.
  - If a new run has opened, the pulse waits for the next frame_done.
- Latency: from an accepted pixel that closes a run to m_aw_valid is at most 3 cycles (push, pop, ADDR) when the output side is idle.
- fifo_level reflects the state after the current cycle's push/pop.
- Simultaneous push and pop on a full data FIFO is allowed: the pop frees the entry first, so the incoming pixel is accepted.

Test Plan:
- Sequential pixels 0..39 at base 0x1000_0000 with m_aw_ready=m_w_ready=1:
  - Expect bursts at 0x1000_0000, +192 and +384 with m_aw_len 47, 47, 23.
  - Expect 120 beats in word order.
  - The last burst is issued only after frame_done; then frame_flushed pulses once.
- Pixels 5, 6, 9, 10, 11 followed by frame_done -> two bursts: addr base+60 with len 5, then addr base+108 with len 8.
- m_w_ready held at 0 while 70 pixels arrive (FIFO_DEPTH=64) -> 6 pixels dropped, drop_count=6, overflow_sticky=1, fifo_level=64. After release, all 64 kept pixels drain correctly. clear_stats zeroes the counters.
- frame_done in the same cycle as pixel 7, which continues the run 4..6 -> one burst of 4 pixels at base+48. frame_flushed follows its last beat.
- Random stall patterns on m_aw_ready and m_w_ready -> valid, addr, data and last stay stable while stalled, and no beat is lost or duplicated (scoreboard against the input).
- rst asserted mid-DATA, after 5 beats of a 48-beat burst -> next cycle all outputs are 0 and fifo_level=0. A fresh pixel 0 plus frame_done then yields a single 3-beat burst.
